// File: rtl/target_generator.sv
// Food target generator: places a pseudo-random legal target from two LFSRs
// and stretches the eat strobe to exactly one score-strobe period.
//
// state | meaning
// PLACE | testing the LFSR pair each cycle until it is legal and off the head
// ARMED | target shown, waiting for the head to land on it
// HOLD  | eat strobe high, counting out ATE_HOLD cycles
module target_generator #(
  parameter int         X_MAX    = 159,
  parameter int         Y_MAX    = 119,
  parameter int         ATE_HOLD = 100000,
  parameter logic [7:0] X_SEED   = 8'h5A,
  parameter logic [6:0] Y_SEED   = 7'h2B
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [7:0] HEAD_X,
  input  logic [6:0] HEAD_Y,
  input  logic       HEAD_VALID,
  output logic [7:0] TARGET_X,
  output logic [6:0] TARGET_Y,
  output logic       TARGET_VALID,
  output logic       TARGET_ATE
);

  localparam logic [7:0]  X_LIM     = X_MAX[7:0];
  localparam logic [6:0]  Y_LIM     = Y_MAX[6:0];
  localparam logic [16:0] HOLD_LAST = 17'(ATE_HOLD - 1);

  typedef enum logic [1:0] {PLACE, ARMED, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  x_lfsr;
  logic [6:0]  y_lfsr;
  logic [16:0] hold_cnt, hold_cnt_nxt;
  logic [7:0]  target_x_nxt;
  logic [6:0]  target_y_nxt;
  logic        target_valid_nxt, target_ate_nxt;
  logic        cand_legal, head_on_target;

  assign cand_legal = (x_lfsr <= X_LIM) && (y_lfsr <= Y_LIM) &&
                      !((x_lfsr == HEAD_X) && (y_lfsr == HEAD_Y));
  assign head_on_target = (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= PLACE;
      x_lfsr       <= X_SEED;
      y_lfsr       <= Y_SEED;
      hold_cnt     <= '0;
      TARGET_X     <= '0;
      TARGET_Y     <= '0;
      TARGET_VALID <= 1'b0;
      TARGET_ATE   <= 1'b0;
    end else begin
      // LFSRs free-run regardless of state so placement keeps exploring new pairs
      x_lfsr       <= {x_lfsr[6:0], x_lfsr[7] ^ x_lfsr[5] ^ x_lfsr[4] ^ x_lfsr[3]};
      y_lfsr       <= {y_lfsr[5:0], y_lfsr[6] ^ y_lfsr[5]};
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      TARGET_X     <= target_x_nxt;
      TARGET_Y     <= target_y_nxt;
      TARGET_VALID <= target_valid_nxt;
      TARGET_ATE   <= target_ate_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    hold_cnt_nxt     = hold_cnt;
    target_x_nxt     = TARGET_X;
    target_y_nxt     = TARGET_Y;
    target_valid_nxt = TARGET_VALID;
    target_ate_nxt   = TARGET_ATE;
    case (state)
      PLACE: begin
        if (cand_legal) begin
          target_x_nxt     = x_lfsr;
          target_y_nxt     = y_lfsr;
          target_valid_nxt = 1'b1;
          state_nxt        = ARMED;
        end
      end
      ARMED: begin
        if (ENABLE && HEAD_VALID && head_on_target) begin
          target_valid_nxt = 1'b0;
          target_ate_nxt   = 1'b1;
          hold_cnt_nxt     = '0;
          state_nxt        = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          target_ate_nxt = 1'b0;
          state_nxt      = PLACE;
        end else begin
          hold_cnt_nxt = hold_cnt + 17'd1;
        end
      end
      default: state_nxt = PLACE;
    endcase
  end

endmodule

// File: tb/tb_target_generator.sv
// Bench for target_generator: directed steps plus randomized head traffic,
// compared every cycle against a cycle-level behavioural model.
module tb_target_generator;

  localparam int HOLD  = 256;
  localparam int RHOLD = 2;
  localparam int RX    = 15;
  localparam int RY    = 15;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b0;
  logic [7:0] HEAD_X = '0;
  logic [6:0] HEAD_Y = '0;
  logic       HEAD_VALID = 1'b0;
  logic [7:0] TARGET_X;
  logic [6:0] TARGET_Y;
  logic       TARGET_VALID;
  logic       TARGET_ATE;

  logic       r_en = 1'b1;
  logic [7:0] r_head_x = '0;
  logic [6:0] r_head_y = '0;
  logic       r_hv = 1'b0;
  logic [7:0] r_tx;
  logic [6:0] r_ty;
  logic       r_valid;
  logic       r_ate;

  int checks = 0;
  int failures = 0;
  int r_places = 0;
  int eats = 0;
  int hi = 0;
  int n = 0;

  logic [7:0] m_x, m_tx;
  logic [6:0] m_y, m_ty;
  bit         m_valid, m_ate;
  int         m_left;

  target_generator #(.ATE_HOLD(HOLD)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y),
    .HEAD_VALID(HEAD_VALID), .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y),
    .TARGET_VALID(TARGET_VALID), .TARGET_ATE(TARGET_ATE)
  );

  target_generator #(.X_MAX(RX), .Y_MAX(RY), .ATE_HOLD(RHOLD)) dut_r (
    .CLK(CLK), .RESET(RESET), .ENABLE(r_en), .HEAD_X(r_head_x), .HEAD_Y(r_head_y),
    .HEAD_VALID(r_hv), .TARGET_X(r_tx), .TARGET_Y(r_ty),
    .TARGET_VALID(r_valid), .TARGET_ATE(r_ate)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] next_x(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [6:0] next_y(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare both DUTs.
  task automatic step();
    logic [7:0] cx;
    logic [6:0] cy;
    bit rp, rleg, rr;
    r_head_x = r_tx;
    r_head_y = r_ty;
    r_hv     = r_valid;
    cx = m_x;
    cy = m_y;
    rr = RESET;
    rp = !r_valid && !r_ate;
    rleg = (int'(cx) <= RX) && (int'(cy) <= RY) && !(cx == r_head_x && cy == r_head_y);
    if (!RESET) begin
      m_x = 8'h5A; m_y = 7'h2B; m_tx = '0; m_ty = '0;
      m_valid = 0; m_ate = 0; m_left = 0;
    end else begin
      m_x = next_x(m_x);
      m_y = next_y(m_y);
      if (!m_valid && !m_ate) begin
        if (int'(cx) <= 159 && int'(cy) <= 119 && !(cx == HEAD_X && cy == HEAD_Y)) begin
          m_tx = cx; m_ty = cy; m_valid = 1;
        end
      end else if (m_valid) begin
        if (ENABLE && HEAD_VALID && HEAD_X == m_tx && HEAD_Y == m_ty) begin
          m_valid = 0; m_ate = 1; m_left = HOLD - 1;
        end
      end else begin
        if (m_left == 0) m_ate = 0;
        else m_left--;
      end
    end
    @(posedge CLK);
    #1;
    chk("target_x", 32'(TARGET_X), 32'(m_tx));
    chk("target_y", 32'(TARGET_Y), 32'(m_ty));
    chk("target_valid", 32'(TARGET_VALID), 32'(m_valid));
    chk("target_ate", 32'(TARGET_ATE), 32'(m_ate));
    if (rr && rp) begin
      chk("range_place_timing", 32'(r_valid), 32'(rleg));
      if (rleg) begin
        r_places++;
        chk("range_place_x", 32'(r_tx), 32'(cx));
        chk("range_place_y", 32'(r_ty), 32'(cy));
        chk("range_in_bounds", 32'(int'(r_tx) <= RX && int'(r_ty) <= RY), 32'd1);
      end
    end
  endtask

  task automatic wait_valid(input int limit);
    n = 0;
    while (!TARGET_VALID && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    RESET = 1'b0;
    repeat (5) step();
    RESET = 1'b1;
    step();
    chk("first_x", 32'(TARGET_X), 32'd90);
    chk("first_y", 32'(TARGET_Y), 32'd43);
    chk("first_valid", 32'(TARGET_VALID), 32'd1);

    ENABLE = 1'b0; HEAD_X = TARGET_X; HEAD_Y = TARGET_Y; HEAD_VALID = 1'b1;
    step();
    chk("suppressed_ate", 32'(TARGET_ATE), 32'd0);
    chk("suppressed_valid", 32'(TARGET_VALID), 32'd1);
    ENABLE = 1'b1; HEAD_X = TARGET_X + 8'd1;
    step();
    chk("nonmatch_ate", 32'(TARGET_ATE), 32'd0);

    HEAD_X = TARGET_X;
    step();
    chk("eat_rise", 32'(TARGET_ATE), 32'd1);
    chk("eat_valid_low", 32'(TARGET_VALID), 32'd0);
    hi = TARGET_ATE ? 1 : 0;
    for (int i = 0; i < HOLD + 1; i++) begin
      HEAD_VALID = 1'($urandom_range(0, 1));
      ENABLE = 1'($urandom_range(0, 1));
      step();
      if (TARGET_ATE) begin
        hi++;
        chk("hold_valid_low", 32'(TARGET_VALID), 32'd0);
      end
    end
    chk("ate_width", 32'(hi), 32'(HOLD));
    HEAD_VALID = 1'b0;
    wait_valid(200);
    chk("new_valid", 32'(TARGET_VALID), 32'd1);
    chk("new_x_range", 32'(TARGET_X >= 8'd1 && TARGET_X <= 8'd159), 32'd1);
    chk("new_y_range", 32'(TARGET_Y >= 7'd1 && TARGET_Y <= 7'd119), 32'd1);

    RESET = 1'b0; HEAD_X = 8'd90; HEAD_Y = 7'd43; HEAD_VALID = 1'b0;
    repeat (3) step();
    RESET = 1'b1;
    step();
    chk("collision_reject", 32'(TARGET_VALID), 32'd0);
    wait_valid(200);
    chk("collision_valid", 32'(TARGET_VALID), 32'd1);
    chk("collision_moved", 32'(TARGET_X != 8'd90 || TARGET_Y != 7'd43), 32'd1);

    ENABLE = 1'b1; HEAD_X = TARGET_X; HEAD_Y = TARGET_Y; HEAD_VALID = 1'b1;
    step();
    chk("eat2_rise", 32'(TARGET_ATE), 32'd1);
    HEAD_VALID = 1'b0;
    repeat (HOLD / 2) step();
    chk("mid_hold_ate", 32'(TARGET_ATE), 32'd1);
    RESET = 1'b0; HEAD_X = '0; HEAD_Y = '0;
    step();
    chk("abort_ate", 32'(TARGET_ATE), 32'd0);
    RESET = 1'b1;
    step();
    chk("replace_x", 32'(TARGET_X), 32'd90);
    chk("replace_y", 32'(TARGET_Y), 32'd43);

    repeat (12000) begin
      ENABLE = ($urandom_range(0, 7) != 0);
      HEAD_VALID = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        HEAD_X = TARGET_X; HEAD_Y = TARGET_Y;
      end else begin
        HEAD_X = 8'($urandom_range(0, 255));
        HEAD_Y = 7'($urandom_range(0, 127));
      end
      step();
      if (TARGET_ATE && m_left == HOLD - 1) eats++;
    end
    chk("random_eats_seen", 32'(eats > 3), 32'd1);
    chk("range_placements", 32'(r_places >= 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
